// File: rtl/fpga_rst_seq_pkg.sv
// Shared types and register map for the FPGA reset/clock sequencer.
package fpga_rst_seq_pkg;

    // Sequencer state encoding. This is the code reported in STATUS[2:0].
    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_SOC_WAIT  = 3'd1,
        ST_CLU_WAIT  = 3'd2,
        ST_RUN       = 3'd3,
        ST_CLU_RST   = 3'd4
    } seq_state_e;

    // Register offsets, decoded from paddr[3:2].
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_SOC_DLY = 2'd1;
    localparam logic [1:0] REG_CLU_DLY = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // CTRL bit indices.
    localparam int CTRL_CLU_RST_REQ   = 0;
    localparam int CTRL_CLU_CLK_EN    = 1;
    localparam int CTRL_CLR_LOCK_LOST = 2;

    // STATUS field positions.
    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_RSTN_SOC  = 3;
    localparam int STAT_RSTN_CLU  = 4;
    localparam int STAT_LOCK_LOST = 5;
    localparam int STATUS_W       = 6;

endpackage

// File: rtl/fpga_rst_seq_ctrl_if.sv
// APB bus bundle for the reset sequencer's register slave.
interface fpga_rst_seq_ctrl_if;
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/fpga_rst_seq_apb_regs.sv
// APB register block: CTRL / SOC_DLY / CLU_DLY storage, STATUS readback,
// write-1 pulse strobes and the error response for writes to STATUS.
module fpga_rst_seq_apb_regs
    import fpga_rst_seq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SOC_DLY_RST = 8,
    parameter int CLU_DLY_RST = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    fpga_rst_seq_ctrl_if.slave  apb,
    input  logic [STATUS_W-1:0] status,
    output logic                clu_rst_req,
    output logic                clr_lock_lost,
    output logic                clu_clk_en,
    output logic [CNT_W-1:0]    soc_dly,
    output logic [CNT_W-1:0]    clu_dly
);

    logic       access;
    logic       wr_en;
    logic [1:0] reg_sel;
    logic       unused_apb;

    assign access  = apb.psel & apb.penable;
    assign wr_en   = access & apb.pwrite;
    assign reg_sel = apb.paddr[3:2];

    // Address and data bits outside the decoded fields are intentionally ignored.
    assign unused_apb = ^{apb.paddr[11:4], apb.paddr[1:0], apb.pwdata[31:CNT_W]};

    // Pulses are live during the access phase so the FSM acts on the same edge.
    assign clu_rst_req   = wr_en && (reg_sel == REG_CTRL) && apb.pwdata[CTRL_CLU_RST_REQ];
    assign clr_lock_lost = wr_en && (reg_sel == REG_CTRL) && apb.pwdata[CTRL_CLR_LOCK_LOST];

    assign apb.pready  = 1'b1;
    assign apb.pslverr = wr_en && (reg_sel == REG_STATUS);

    // Register writes complete on the access-phase edge; STATUS writes are dropped.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clu_clk_en <= 1'b1;
            soc_dly    <= CNT_W'(SOC_DLY_RST);
            clu_dly    <= CNT_W'(CLU_DLY_RST);
        end else if (wr_en) begin
            case (reg_sel)
                REG_CTRL:    clu_clk_en <= apb.pwdata[CTRL_CLU_CLK_EN];
                REG_SOC_DLY: soc_dly    <= apb.pwdata[CNT_W-1:0];
                REG_CLU_DLY: clu_dly    <= apb.pwdata[CNT_W-1:0];
                default:     ;
            endcase
        end
    end

    // Read mux; returns zero whenever no read is selected.
    always_comb begin
        // NOTE: default assignment first so every path drives prdata and no latch is inferred.
        apb.prdata = '0;
        if (apb.psel && !apb.pwrite) begin
            case (reg_sel)
                REG_CTRL:    apb.prdata[CTRL_CLU_CLK_EN]  = clu_clk_en;
                REG_SOC_DLY: apb.prdata[CNT_W-1:0]        = soc_dly;
                REG_CLU_DLY: apb.prdata[CNT_W-1:0]        = clu_dly;
                default:     apb.prdata[STATUS_W-1:0]     = status;
            endcase
        end
    end

endmodule

// File: rtl/fpga_rst_seq_ctrl.sv
// Reset/clock sequencer: filters PLL lock, then releases SoC reset and
// later cluster reset after programmable delays; handles software cluster
// reset and lock loss.
module fpga_rst_seq_ctrl
    import fpga_rst_seq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LOCK_FILT   = 4,
    parameter int SOC_DLY_RST = 8,
    parameter int CLU_DLY_RST = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pll_locked_i,
    fpga_rst_seq_ctrl_if.slave apb,
    output logic               rstn_soc_o,
    output logic               rstn_cluster_o,
    output logic               clk_cluster_en_o
);

    localparam int LCNT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
    localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(LOCK_FILT - 1);

    seq_state_e          state;
    logic [LCNT_W-1:0]   lock_cnt;
    logic [CNT_W-1:0]    cnt;
    logic                lock_lost;
    logic                clu_rst_req;
    logic                clr_lock_lost;
    logic                clu_clk_en;
    logic [CNT_W-1:0]    soc_dly;
    logic [CNT_W-1:0]    clu_dly;
    logic [STATUS_W-1:0] status;

    assign status = {lock_lost, rstn_cluster_o, rstn_soc_o, state};

    // The CTRL clock-enable bit is itself a flop, so it drives the gate directly.
    assign clk_cluster_en_o = clu_clk_en;

    fpga_rst_seq_apb_regs #(
        .CNT_W       (CNT_W),
        .SOC_DLY_RST (SOC_DLY_RST),
        .CLU_DLY_RST (CLU_DLY_RST)
    ) u_regs (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .apb           (apb),
        .status        (status),
        .clu_rst_req   (clu_rst_req),
        .clr_lock_lost (clr_lock_lost),
        .clu_clk_en    (clu_clk_en),
        .soc_dly       (soc_dly),
        .clu_dly       (clu_dly)
    );

    // Sequencer FSM with counters and registered reset outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= ST_WAIT_LOCK;
            lock_cnt       <= '0;
            cnt            <= '0;
            rstn_soc_o     <= 1'b0;
            rstn_cluster_o <= 1'b0;
            lock_lost      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge values; the later
            // lock_lost set below overrides this clear when both happen on one edge.
            if (clr_lock_lost) begin
                lock_lost <= 1'b0;
            end

            if (!pll_locked_i && (state != ST_WAIT_LOCK)) begin
                // Lock loss outranks every other transition and APB request.
                rstn_soc_o     <= 1'b0;
                rstn_cluster_o <= 1'b0;
                lock_cnt       <= '0;
                state          <= ST_WAIT_LOCK;
                if ((state == ST_RUN) || (state == ST_CLU_RST)) begin
                    lock_lost <= 1'b1;
                end
            end else begin
                case (state)
                    ST_WAIT_LOCK: begin
                        if (!pll_locked_i) begin
                            lock_cnt <= '0;
                        end else if (lock_cnt == LOCK_LAST) begin
                            lock_cnt <= '0;
                            cnt      <= soc_dly;
                            state    <= ST_SOC_WAIT;
                        end else begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end
                    end
                    ST_SOC_WAIT: begin
                        if (cnt == '0) begin
                            rstn_soc_o <= 1'b1;
                            cnt        <= clu_dly;
                            state      <= ST_CLU_WAIT;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_CLU_WAIT: begin
                        if (cnt == '0) begin
                            rstn_cluster_o <= 1'b1;
                            state          <= ST_RUN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (clu_rst_req) begin
                            rstn_cluster_o <= 1'b0;
                            cnt            <= clu_dly;
                            state          <= ST_CLU_RST;
                        end
                    end
                    ST_CLU_RST: begin
                        if (cnt == '0) begin
                            rstn_cluster_o <= 1'b1;
                            state          <= ST_RUN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        // Unused codes recover to a safe, fully reset state.
                        rstn_soc_o     <= 1'b0;
                        rstn_cluster_o <= 1'b0;
                        lock_cnt       <= '0;
                        state          <= ST_WAIT_LOCK;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpga_rst_seq_ctrl.sv
// Directed bench for the reset sequencer; expected values are hand-computed
// edge counts and register images.
module tb_fpga_rst_seq_ctrl;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic pll_locked_i = 1'b0;
    logic rstn_soc_o;
    logic rstn_cluster_o;
    logic clk_cluster_en_o;

    int n_checks = 0;
    int n_fail   = 0;

    fpga_rst_seq_ctrl_if apb_if ();

    fpga_rst_seq_ctrl dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .pll_locked_i     (pll_locked_i),
        .apb              (apb_if),
        .rstn_soc_o       (rstn_soc_o),
        .rstn_cluster_o   (rstn_cluster_o),
        .clk_cluster_en_o (clk_cluster_en_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One rising edge; returns at the following falling edge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic apb_idle();
        apb_if.psel    = 1'b0;
        apb_if.penable = 1'b0;
        apb_if.pwrite  = 1'b0;
        apb_if.paddr   = '0;
        apb_if.pwdata  = '0;
    endtask

    // Two edges: setup, then access (the write lands on the access edge).
    task automatic apb_write(input logic [11:0] addr, input logic [31:0] data, output logic err);
        apb_if.psel   = 1'b1;
        apb_if.pwrite = 1'b1;
        apb_if.paddr  = addr;
        apb_if.pwdata = data;
        tick();
        apb_if.penable = 1'b1;
        #1;
        err = apb_if.pslverr;
        tick();
        apb_idle();
    endtask

    task automatic apb_read(input logic [11:0] addr, output logic [31:0] data);
        apb_if.psel   = 1'b1;
        apb_if.pwrite = 1'b0;
        apb_if.paddr  = addr;
        tick();
        apb_if.penable = 1'b1;
        #1;
        data = apb_if.prdata;
        tick();
        apb_idle();
    endtask

    task automatic do_reset(input logic lock);
        @(negedge clk_i);
        rst_ni       = 1'b0;
        pll_locked_i = lock;
        apb_idle();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    logic [31:0] rd;
    logic        err;

    initial begin
        apb_idle();

        // Power-up with lock high from the first edge: soc at edge 13, cluster at edge 30.
        do_reset(1'b1);
        check("rst_soc", 32'(rstn_soc_o), 32'd0);
        check("rst_clu", 32'(rstn_cluster_o), 32'd0);
        check("rst_clk_en", 32'(clk_cluster_en_o), 32'd1);
        check("rst_prdata", apb_if.prdata, 32'h0);
        check("rst_pslverr", 32'(apb_if.pslverr), 32'd0);
        check("rst_pready", 32'(apb_if.pready), 32'd1);
        repeat (12) tick();
        check("pu_soc_e12", 32'(rstn_soc_o), 32'd0);
        tick();
        check("pu_soc_e13", 32'(rstn_soc_o), 32'd1);
        check("pu_clu_e13", 32'(rstn_cluster_o), 32'd0);
        repeat (16) tick();
        check("pu_clu_e29", 32'(rstn_cluster_o), 32'd0);
        tick();
        check("pu_clu_e30", 32'(rstn_cluster_o), 32'd1);
        apb_read(12'hC, rd);
        check("pu_status", rd, 32'h1B);

        // Zero delays: soc at edge 5, cluster at edge 6.
        do_reset(1'b0);
        apb_write(12'h4, 32'h0, err);
        check("wr_soc_dly_err", 32'(err), 32'd0);
        apb_write(12'h8, 32'h0, err);
        apb_read(12'h4, rd);
        check("rd_soc_dly0", rd, 32'h0);
        pll_locked_i = 1'b1;
        repeat (4) tick();
        check("z_soc_e4", 32'(rstn_soc_o), 32'd0);
        tick();
        check("z_soc_e5", 32'(rstn_soc_o), 32'd1);
        check("z_clu_e5", 32'(rstn_cluster_o), 32'd0);
        tick();
        check("z_clu_e6", 32'(rstn_cluster_o), 32'd1);

        // Lock glitch: three highs then a low restart the filter.
        do_reset(1'b0);
        pll_locked_i = 1'b1;
        repeat (3) tick();
        pll_locked_i = 1'b0;
        apb_read(12'hC, rd);
        check("gl_status", rd, 32'h0);
        pll_locked_i = 1'b1;
        repeat (12) tick();
        check("gl_soc_e12", 32'(rstn_soc_o), 32'd0);
        tick();
        check("gl_soc_e13", 32'(rstn_soc_o), 32'd1);
        repeat (16) tick();
        check("gl_clu_e29", 32'(rstn_cluster_o), 32'd0);
        tick();
        check("gl_clu_e30", 32'(rstn_cluster_o), 32'd1);

        // Software cluster reset in RUN: low for 17 edges, SoC untouched.
        apb_write(12'h0, 32'h3, err);
        check("sw_clu_low", 32'(rstn_cluster_o), 32'd0);
        repeat (16) tick();
        check("sw_clu_e16", 32'(rstn_cluster_o), 32'd0);
        check("sw_soc_hold", 32'(rstn_soc_o), 32'd1);
        tick();
        check("sw_clu_e17", 32'(rstn_cluster_o), 32'd1);
        apb_read(12'h0, rd);
        check("sw_ctrl_rd", rd, 32'h2);
        apb_write(12'h0, 32'h0, err);
        check("clk_en_off", 32'(clk_cluster_en_o), 32'd0);
        apb_write(12'h0, 32'h2, err);
        check("clk_en_on", 32'(clk_cluster_en_o), 32'd1);

        // Lock loss in CLU_RST with a simultaneous clr_lock_lost write: set wins.
        apb_write(12'h0, 32'h3, err);
        repeat (3) tick();
        apb_if.psel   = 1'b1;
        apb_if.pwrite = 1'b1;
        apb_if.paddr  = 12'h0;
        apb_if.pwdata = 32'h6;
        tick();
        apb_if.penable = 1'b1;
        pll_locked_i   = 1'b0;
        tick();
        apb_idle();
        check("ll_soc", 32'(rstn_soc_o), 32'd0);
        check("ll_clu", 32'(rstn_cluster_o), 32'd0);
        apb_read(12'hC, rd);
        check("ll_status", rd, 32'h20);
        apb_write(12'h0, 32'h6, err);
        apb_read(12'hC, rd);
        check("ll_cleared", rd, 32'h0);

        // Write to STATUS is rejected and ignored.
        apb_write(12'hC, 32'hFF, err);
        check("st_wr_err", 32'(err), 32'd1);
        apb_read(12'hC, rd);
        check("st_unchanged", rd, 32'h0);

        // clu_rst_req during SOC_WAIT is dropped; timing unchanged.
        pll_locked_i = 1'b1;
        repeat (5) tick();
        apb_write(12'h0, 32'h3, err);
        repeat (5) tick();
        check("ig_soc_e12", 32'(rstn_soc_o), 32'd0);
        tick();
        check("ig_soc_e13", 32'(rstn_soc_o), 32'd1);
        repeat (16) tick();
        check("ig_clu_e29", 32'(rstn_cluster_o), 32'd0);
        tick();
        check("ig_clu_e30", 32'(rstn_cluster_o), 32'd1);
        apb_read(12'hC, rd);
        check("ig_status", rd, 32'h1B);

        // Asynchronous reset mid-run clears outputs without waiting for an edge.
        #2;
        rst_ni = 1'b0;
        #1;
        check("ar_soc", 32'(rstn_soc_o), 32'd0);
        check("ar_clu", 32'(rstn_cluster_o), 32'd0);
        check("ar_clk_en", 32'(clk_cluster_en_o), 32'd1);
        @(negedge clk_i);
        pll_locked_i = 1'b0;
        rst_ni = 1'b1;
        apb_read(12'h4, rd);
        check("ar_soc_dly", rd, 32'd8);
        apb_read(12'h8, rd);
        check("ar_clu_dly", rd, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
